shift_reg_sched: RTL and testbench

//   Two-requester scheduler and sequencer for a WIDTH-bit serial shift path.

---
 rtl/shift_reg_sched_pkg.sv | 25 ++
 rtl/shift_reg_sched_rr_arb2.sv | 12 +
 rtl/shift_reg_sched.sv | 129 ++++++++++++
 tb/tb_shift_reg_sched.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_sched_pkg.sv
// Shared state codes, widths and the round-robin pick rule for the serial shift scheduler.
package shift_reg_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    localparam int GAP_W = 4;

    // Two-way round-robin: a lone requester wins; with both requesting, the one that did not win last.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
        logic [1:0] gnt;
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        return gnt;
    endfunction

endpackage

// File: rtl/shift_reg_sched_rr_arb2.sv
// Combinational two-way round-robin arbiter; last_i is the index of the previous winner.
module rr_arb2
    import shift_reg_sched_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    assign gnt_o = rr_pick(req_i, last_i);

endmodule

// File: rtl/shift_reg_sched.sv
// Two-requester scheduler that loads the granted word and shifts it out MSB-first.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for a request; grant is combinational this cycle
//   ST_SHIFT | one bit per non-stalled cycle, cnt counts bits remaining
//   ST_GAP   | GAP idle cycles between frames, STALL ignored
module shift_reg_sched
    import shift_reg_sched_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [1:0]       req_i,
    input  logic [WIDTH-1:0] data0_i,
    input  logic [WIDTH-1:0] data1_i,
    output logic [1:0]       gnt_o,
    input  logic             stall_i,
    output logic             sout_o,
    output logic             svalid_o,
    output logic             sowner_o,
    output logic             busy_o,
    output logic [1:0]       done_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               owner_q, owner_d;
    logic               last_q, last_d;
    logic [1:0]         done_q, done_d;
    logic [1:0]         arb_gnt;
    logic [1:0]         gnt;

    rr_arb2 u_arb (
        .req_i  (req_i),
        .last_i (last_q),
        .gnt_o  (arb_gnt)
    );

    // State, datapath and pointer registers; pointer starts at 1 so requester 0 wins first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            done_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    // Next-state, grant and datapath update.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        owner_d = owner_q;
        last_d  = last_q;
        done_d  = 2'b00;
        gnt     = 2'b00;

        case (state_q)
            ST_IDLE: begin
                // GNT stays low while reset is held, even though the state is already IDLE.
                if (rst_ni) begin
                    gnt = arb_gnt;
                end
                if (gnt != 2'b00) begin
                    sr_d    = gnt[1] ? data1_i : data0_i;
                    cnt_d   = CNT_W'(WIDTH);
                    owner_d = gnt[1];
                    last_d  = gnt[1];
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!stall_i) begin
                    sr_d  = sr_q << 1;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        done_d = owner_q ? 2'b10 : 2'b01;
                        if (GAP > 0) begin
                            gap_d   = GAP_W'(GAP);
                            state_d = ST_GAP;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_GAP: begin
                // gap_q holds the GAP cycles still to spend here, including this one.
                if (gap_q <= GAP_W'(1)) begin
                    gap_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign gnt_o    = gnt;
    assign sout_o   = (state_q == ST_SHIFT) ? sr_q[WIDTH-1] : 1'b0;
    assign svalid_o = (state_q == ST_SHIFT) && !stall_i;
    assign sowner_o = owner_q;
    assign busy_o   = (state_q != ST_IDLE);
    assign done_o   = done_q;

endmodule

// File: tb/tb_shift_reg_sched.sv
// Bench for shift_reg_sched: a GAP=1 and a GAP=0 instance, checked every cycle against a frame-level model.
module tb_shift_reg_sched;

    localparam int W    = 4;
    localparam int NDUT = 2;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       req    [NDUT];
    logic [W-1:0]     d0     [NDUT];
    logic [W-1:0]     d1     [NDUT];
    logic             stall  [NDUT];
    logic [1:0]       gnt    [NDUT];
    logic             sout   [NDUT];
    logic             svalid [NDUT];
    logic             sowner [NDUT];
    logic             busy   [NDUT];
    logic [1:0]       done   [NDUT];
    logic [1:0]       gnt_seen [NDUT];

    int n_chk  = 0;
    int n_fail = 0;

    // Frame-level reference: which word is on the wire, which bit is next, gap cycles still owed.
    int           m_left  [NDUT];
    int           m_idx   [NDUT];
    int           m_gap   [NDUT];
    logic [W-1:0] m_word  [NDUT];
    logic         m_owner [NDUT];
    logic         m_last  [NDUT];
    logic [1:0]   m_done  [NDUT];

    shift_reg_sched #(.WIDTH(W), .GAP(1)) u_dut_g1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .data0_i(d0[0]), .data1_i(d1[0]),
        .gnt_o(gnt[0]), .stall_i(stall[0]), .sout_o(sout[0]), .svalid_o(svalid[0]),
        .sowner_o(sowner[0]), .busy_o(busy[0]), .done_o(done[0])
    );

    shift_reg_sched #(.WIDTH(W), .GAP(0)) u_dut_g0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .data0_i(d0[1]), .data1_i(d1[1]),
        .gnt_o(gnt[1]), .stall_i(stall[1]), .sout_o(sout[1]), .svalid_o(svalid[1]),
        .sowner_o(sowner[1]), .busy_o(busy[1]), .done_o(done[1])
    );

    always #5 clk = ~clk;

    function automatic int gap_of(input int k);
        return (k == 0) ? 1 : 0;
    endfunction

    function automatic logic [1:0] ref_winner(input logic [1:0] r, input logic last);
        if (r == 2'b11) return last ? 2'b01 : 2'b10;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance the reference on each clock edge using the inputs that were present before the edge.
    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < NDUT; k++) begin
            if (!rst_n) begin
                m_left[k] = 0; m_idx[k] = 0; m_gap[k] = 0; m_word[k] = '0;
                m_owner[k] = 1'b0; m_last[k] = 1'b1; m_done[k] = 2'b00;
            end else begin
                logic [1:0] w;
                m_done[k] = 2'b00;
                if (m_left[k] > 0) begin
                    if (!stall[k]) begin
                        m_idx[k]++;
                        m_left[k]--;
                        if (m_left[k] == 0) begin
                            m_done[k] = m_owner[k] ? 2'b10 : 2'b01;
                            m_gap[k]  = gap_of(k);
                        end
                    end
                end else if (m_gap[k] > 0) begin
                    m_gap[k]--;
                end else begin
                    w = ref_winner(req[k], m_last[k]);
                    if (w != 2'b00) begin
                        m_owner[k] = w[1];
                        m_last[k]  = w[1];
                        m_word[k]  = w[1] ? d1[k] : d0[k];
                        m_idx[k]   = 0;
                        m_left[k]  = W;
                    end
                end
            end
        end
    end

    // Compare every output against the reference mid-cycle.
    always @(negedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            logic [1:0] e_gnt;
            logic e_sv, e_so, e_busy;
            e_gnt = 2'b00; e_sv = 1'b0; e_so = 1'b0; e_busy = 1'b0;
            if (rst_n) begin
                if (m_left[k] > 0) begin
                    e_busy = 1'b1;
                    e_sv   = !stall[k];
                    e_so   = m_word[k][W-1-m_idx[k]];
                end else if (m_gap[k] > 0) begin
                    e_busy = 1'b1;
                end else begin
                    e_gnt = ref_winner(req[k], m_last[k]);
                end
            end
            chk($sformatf("d%0d_gnt", k),    32'(gnt[k]),    32'(e_gnt));
            chk($sformatf("d%0d_svalid", k), 32'(svalid[k]), 32'(e_sv));
            chk($sformatf("d%0d_busy", k),   32'(busy[k]),   32'(e_busy));
            chk($sformatf("d%0d_done", k),   32'(done[k]),   32'(m_done[k]));
            chk($sformatf("d%0d_sowner", k), 32'(sowner[k]), 32'(m_owner[k]));
            if (e_sv) chk($sformatf("d%0d_sout", k), 32'(sout[k]), 32'(e_so));
            else if (m_left[k] > 0) chk($sformatf("d%0d_sout_hold", k), 32'(sout[k]), 32'(e_so));
            gnt_seen[k] = gnt[k];
        end
    end

    // mode 0: drop request on grant; mode 1: re-request same word; mode 2: random traffic.
    task automatic next_cycle(input int mode);
        @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            for (int i = 0; i < 2; i++) begin
                logic [W-1:0] nd;
                nd = W'($urandom);
                if (req[k][i] && gnt_seen[k][i]) begin
                    if (mode == 0) req[k][i] = 1'b0;
                    else if (mode == 2) begin
                        req[k][i] = 1'($urandom_range(0, 1));
                        if (i == 0) d0[k] = nd; else d1[k] = nd;
                    end
                end else if (mode == 2) begin
                    if (req[k][i]) begin
                        if ($urandom_range(0, 15) == 0) req[k][i] = 1'b0;
                    end else if ($urandom_range(0, 2) == 0) begin
                        req[k][i] = 1'b1;
                        if (i == 0) d0[k] = nd; else d1[k] = nd;
                    end
                end
            end
            if (mode == 2) stall[k] = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic set_all(input logic [1:0] r, input logic [W-1:0] a, input logic [W-1:0] b);
        for (int k = 0; k < NDUT; k++) begin
            req[k] = r; d0[k] = a; d1[k] = b; stall[k] = 1'b0;
        end
    endtask

    initial begin
        for (int k = 0; k < NDUT; k++) gnt_seen[k] = 2'b00;
        set_all(2'b11, 4'hF, 4'hF);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_all(2'b00, 4'h0, 4'h0);
        repeat (2) next_cycle(0);

        // Single frame 1011 from requester 0.
        set_all(2'b01, 4'b1011, 4'h0);
        repeat (8) next_cycle(0);

        // Both requesting, alternating grants.
        set_all(2'b11, 4'hA, 4'h5);
        repeat (30) next_cycle(1);
        repeat (8) next_cycle(0);

        // Stall during the frame: stall high in cycles 2 and 3 after the grant cycle.
        set_all(2'b01, 4'b1100, 4'h0);
        next_cycle(0);
        next_cycle(0);
        for (int k = 0; k < NDUT; k++) stall[k] = 1'b1;
        next_cycle(0);
        next_cycle(0);
        for (int k = 0; k < NDUT; k++) stall[k] = 1'b0;
        repeat (8) next_cycle(0);

        // Reset during the second bit of a requester-1 frame.
        set_all(2'b10, 4'b1111, 4'b1111);
        next_cycle(0);
        next_cycle(0);
        #2;
        chk("pre_reset_svalid", 32'(svalid[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_svalid", 32'(svalid[0]), 32'd0);
        chk("rst_busy",   32'(busy[0]),   32'd0);
        chk("rst_sout",   32'(sout[0]),   32'd0);
        chk("rst_done",   32'(done[0]),   32'd0);
        chk("rst_sowner", 32'(sowner[0]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        set_all(2'b11, 4'h3, 4'hC);
        rst_n = 1'b1;
        #1;
        chk("post_reset_gnt", 32'(gnt[0]), 32'd1);
        repeat (12) next_cycle(0);

        // Randomized traffic with stalls.
        for (int n = 0; n < 3000; n++) next_cycle(2);

        for (int k = 0; k < NDUT; k++) stall[k] = 1'b0;
        repeat (40) next_cycle(0);
        chk("drain_busy0", 32'(busy[0]), 32'd0);
        chk("drain_busy1", 32'(busy[1]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
